sa_skew_feeder: RTL and testbench
=================================

Name: sa_skew_feeder

Overview:
- Operand feeder directly upstream of the 2D output-stationary systolic array (sa_2D).
- Accepts one K-slice per beat: column k of the A tile and row k of the B tile, HPE lanes each.
- Applies the diagonal skew the array needs: lane z is delayed z extra cycles. Injects zero bubbles on stalls and flushes zeros until the last product has reached the bottom-right PE, then pulses done.

Parameters:
- HPE, 64, lanes per operand; equals the array edge size. Drives the AA/BB width and the skew depth.
- WIDTH, 32, operand width per lane.
- KW, 16, width of the K-length field and beat counter.
- PE_LAT, 1, PE MAC register latency added to the flush length.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- k_len  in  KW  number of K beats in the frame; sampled with start.
- a_vec  in  WIDTH*HPE  A column slice; lane z = bits [(z+1)*WIDTH-1 : z*WIDTH].
- b_vec  in  WIDTH*HPE  B row slice; same lane packing.
- in_valid  in  1  a_vec/b_vec valid.
- in_ready  out  1  feeder accepts a beat; accept = in_valid & in_ready.
- AA  out  WIDTH*HPE  skewed A operands to the array (lane z -> Ain[z]).
- BB  out  WIDTH*HPE  skewed B operands to the array (lane z -> Bin[z]).
- busy  out  1  high in LOAD and FLUSH.
- done  out  1  one-cycle pulse when the frame's last product has been issued to PE[HPE-1][HPE-1].

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE; beat and flush counters=0; all skew registers=0.
  - AA=BB=0, in_ready=0, busy=0, done=0.
  - RST overrides every other input. Reset mid-frame aborts the frame with no done; zeros reach AA/BB from the next cycle.
- Skew pipeline (free-running, advances every cycle in every state):
  - Per lane z, the injected value is the lane-z operand on accept, else 0.
  - Lane z output = injected value delayed z+1 cycles. Lane 0 has 1 register; lane HPE-1 has HPE registers.
  - Total storage per operand: WIDTH*HPE*(HPE+1)/2 bits; AA and BB skewed identically.
  - Stall bubbles insert a whole zero diagonal, so A/B alignment is preserved and zero products are harmless.
  - AA/BB are straight register outputs; no arithmetic, no width change.
- FSM:
  - IDLE:
    - in_ready=0, busy=0.
    - start=1 and k_len!=0 -> LOAD, beat counter cleared.
    - start=1 with k_len=0 is ignored: stays IDLE, no done.
  - LOAD:
    - in_ready=1, busy=1.
    - Each accept increments the beat counter.
    - Accept of beat k_len-1 -> FLUSH, flush counter loaded with D = 2*HPE-1+PE_LAT.
    - in_valid=0 cycles keep LOAD and inject zeros.
  - FLUSH:
    - in_ready=0, busy=1, zeros injected.
    - Counter decrements each cycle; when it reaches 1, next state = IDLE with done=1 for that single IDLE cycle.
  - start while busy is ignored; k_len is latched only at start.
- Timing:
  - Last accept at edge t -> FLUSH cycles t+1..t+D -> done high during cycle t+D+1.
  - First accept at edge t -> AA lane z carries beat 0 during cycle t+z+1.
- Counters: the beat counter saturates at k_len-1 and never wraps; k_len = 2^KW-1 must be supported.

Decomposition:
- Shared package sa_pkg: FSM state encoding (IDLE/LOAD/FLUSH), lane slice helper, function returning D from HPE and PE_LAT.
- One sub-module: sa_skew_lane (parameters WIDTH and DEPTH), a zero-reset shift register, instantiated 2*HPE times via generate with DEPTH=z+1.
- Top level holds the FSM and counters.

Test Plan (HPE=4, WIDTH=8, KW=8, PE_LAT=1, so D=8):
- Reset: hold RST 3 cycles with random inputs -> AA=BB=0, in_ready=0, busy=0, done=0; one cycle after release still IDLE.
- Single beat: start with k_len=1; accept a lanes {1,2,3,4}, b lanes {5,6,7,8} at edge t.
  - AA lane0=1 / BB lane0=5 at t+1; lane3=4 / 8 at t+4; all other cycles 0.
  - done high exactly in cycle t+9; busy low from t+9.
- Stall bubble: k_len=3, in_valid low for one cycle between beats 1 and 2.
  - Zero diagonal appears in AA/BB between beats; in_ready stays 1.
  - Exactly 3 accepts; done at last accept + 9.
- Ignored starts: start with k_len=0 -> no busy, no done. start with k_len=5 pulsed during FLUSH -> frame unaffected, single done.
- Reset mid-LOAD after 2 of 4 beats: next cycle IDLE, AA=BB=0, no done ever; a new start works normally.
- End-to-end with sa_2D: 4x4 A=identity, random B, k_len=4 -> after done, array Y equals B element-wise (64-bit results).

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array skew feeder: FSM encoding,
// lane slice offset helper and flush length computation.
package sa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2
   } sa_state_e;

   // Bit offset of lane z in a flat lane-packed operand vector.
   function automatic int unsigned lane_lsb(input int unsigned lane,
                                            input int unsigned width);
      return lane * width;
   endfunction

   // Cycles from the last accept until the last product has entered PE[HPE-1][HPE-1].
   function automatic int unsigned flush_len(input int unsigned hpe,
                                             input int unsigned pe_lat);
      return 2 * hpe - 1 + pe_lat;
   endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// Zero-reset shift register delaying one operand lane by DEPTH cycles.
module sa_skew_lane #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   // Index 0 holds the newest sample, index DEPTH-1 the oldest.
   logic [DEPTH-1:0][WIDTH-1:0] r_sr;

   generate
      if (DEPTH == 1) begin : g_one
         always_ff @(posedge CLK) begin
            if (RST) r_sr <= '0;
            else     r_sr <= i_d;
         end
      end else begin : g_chain
         always_ff @(posedge CLK) begin
            if (RST) r_sr <= '0;
            else     r_sr <= {r_sr[DEPTH-2:0], i_d};
         end
      end
   endgenerate

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Operand feeder for the output-stationary systolic array: accepts K-slices,
// applies the diagonal lane skew, flushes zeros and pulses done per frame.
module sa_skew_feeder
   import sa_pkg::*;
#(
   parameter int unsigned HPE    = 64,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned KW     = 16,
   parameter int unsigned PE_LAT = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic [KW-1:0]        k_len,
   input  logic [WIDTH*HPE-1:0] a_vec,
   input  logic [WIDTH*HPE-1:0] b_vec,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH*HPE-1:0] AA,
   output logic [WIDTH*HPE-1:0] BB,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned D  = flush_len(HPE, PE_LAT);
   localparam int unsigned FW = $clog2(D + 1);

   sa_state_e     r_state;
   sa_state_e     w_state_nxt;
   logic [KW-1:0] r_klen;
   logic [KW-1:0] w_klen_nxt;
   logic [KW-1:0] r_beat;
   logic [KW-1:0] w_beat_nxt;
   logic [FW-1:0] r_flush;
   logic [FW-1:0] w_flush_nxt;
   logic          r_in_ready;
   logic          r_busy;
   logic          r_done;
   logic          w_done_nxt;
   logic          w_accept;
   logic          w_last_beat;

   assign w_accept    = in_valid & r_in_ready;
   assign w_last_beat = (r_beat == (r_klen - KW'(1)));

   // State, counters and registered handshake/status flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_klen     <= '0;
         r_beat     <= '0;
         r_flush    <= '0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_klen     <= w_klen_nxt;
         r_beat     <= w_beat_nxt;
         r_flush    <= w_flush_nxt;
         r_in_ready <= (w_state_nxt == ST_LOAD);
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_done     <= w_done_nxt;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_klen_nxt  = r_klen;
      w_beat_nxt  = r_beat;
      w_flush_nxt = r_flush;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && (k_len != '0)) begin
               w_state_nxt = ST_LOAD;
               w_klen_nxt  = k_len;
               w_beat_nxt  = '0;
            end
         end
         ST_LOAD: begin
            if (w_accept) begin
               if (w_last_beat) begin
                  w_state_nxt = ST_FLUSH;
                  w_flush_nxt = FW'(D);
               end else begin
                  w_beat_nxt  = r_beat + KW'(1);
               end
            end
         end
         ST_FLUSH: begin
            w_flush_nxt = r_flush - FW'(1);
            if (r_flush == FW'(1)) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Per-lane skew chains; non-accept cycles inject a zero diagonal.
   for (genvar z = 0; z < HPE; z++) begin : g_lane
      localparam int unsigned LSB = lane_lsb(z, WIDTH);
      logic [WIDTH-1:0] w_a_inj;
      logic [WIDTH-1:0] w_b_inj;

      assign w_a_inj = w_accept ? a_vec[LSB +: WIDTH] : '0;
      assign w_b_inj = w_accept ? b_vec[LSB +: WIDTH] : '0;

      sa_skew_lane #(.WIDTH(WIDTH), .DEPTH(z + 1)) u_a (
         .CLK (CLK),
         .RST (RST),
         .i_d (w_a_inj),
         .o_q (AA[LSB +: WIDTH])
      );

      sa_skew_lane #(.WIDTH(WIDTH), .DEPTH(z + 1)) u_b (
         .CLK (CLK),
         .RST (RST),
         .i_d (w_b_inj),
         .o_q (BB[LSB +: WIDTH])
      );
   end

   assign in_ready = r_in_ready;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: timestamp/history reference model,
// literal timing checks and a behavioural output-stationary array downstream.
module tb_sa_skew_feeder;

   localparam int HPE    = 4;
   localparam int WIDTH  = 8;
   localparam int KW     = 8;
   localparam int PE_LAT = 1;
   localparam int VW     = WIDTH * HPE;
   localparam int D      = 2 * HPE - 1 + PE_LAT;

   logic          CLK = 1'b0;
   logic          RST;
   logic          start;
   logic [KW-1:0] k_len;
   logic [VW-1:0] a_vec;
   logic [VW-1:0] b_vec;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] AA;
   logic [VW-1:0] BB;
   logic          busy;
   logic          done;

   sa_skew_feeder #(.HPE(HPE), .WIDTH(WIDTH), .KW(KW), .PE_LAT(PE_LAT)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .start    (start),
      .k_len    (k_len),
      .a_vec    (a_vec),
      .b_vec    (b_vec),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .AA       (AA),
      .BB       (BB),
      .busy     (busy),
      .done     (done)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: injection history plus frame timestamps.
   bit            m_started = 1'b0;
   bit            m_ready   = 1'b0;
   bit            m_busy    = 1'b0;
   bit            m_done    = 1'b0;
   int            m_left    = 0;
   int            m_done_at = -1;
   logic [VW-1:0] hist_a [HPE];
   logic [VW-1:0] hist_b [HPE];
   bit            m_acc;
   bit            m_nd;

   always @(posedge CLK) begin : b_model
      cyc = cyc + 1;
      m_started = 1'b1;
      if (RST) begin
         for (int z = 0; z < HPE; z++) begin
            hist_a[z] = '0;
            hist_b[z] = '0;
         end
         m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0;
         m_left = 0; m_done_at = -1;
      end else begin
         m_acc = in_valid && m_ready;
         m_nd  = (cyc == m_done_at);
         for (int z = HPE - 1; z > 0; z--) begin
            hist_a[z] = hist_a[z-1];
            hist_b[z] = hist_b[z-1];
         end
         hist_a[0] = m_acc ? a_vec : '0;
         hist_b[0] = m_acc ? b_vec : '0;
         if (!m_busy && start && (k_len != 0)) begin
            m_left  = int'(k_len);
            m_ready = 1'b1;
            m_busy  = 1'b1;
         end else if (m_acc) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_ready   = 1'b0;
               m_done_at = cyc + D;
            end
         end
         if (m_nd) m_busy = 1'b0;
         m_done = m_nd;
      end
   end

   // Every-cycle comparison against the model, mid-cycle.
   logic [VW-1:0] exp_aa, exp_bb;
   always @(negedge CLK) begin : b_compare
      if (m_started) begin
         for (int z = 0; z < HPE; z++) begin
            exp_aa[z*WIDTH +: WIDTH] = hist_a[z][z*WIDTH +: WIDTH];
            exp_bb[z*WIDTH +: WIDTH] = hist_b[z][z*WIDTH +: WIDTH];
         end
         chk("cmp_AA", 64'(AA), 64'(exp_aa));
         chk("cmp_BB", 64'(BB), 64'(exp_bb));
         chk("cmp_in_ready", 64'(in_ready), 64'(m_ready));
         chk("cmp_busy", 64'(busy), 64'(m_busy));
         chk("cmp_done", 64'(done), 64'(m_done));
      end
   end

   // Behavioural output-stationary array fed by AA (rows) and BB (columns).
   logic [WIDTH-1:0] ar_a [HPE][HPE];
   logic [WIDTH-1:0] ar_b [HPE][HPE];
   longint unsigned  y_acc [HPE][HPE];
   logic [WIDTH-1:0] pa, pb;

   always @(negedge CLK) begin : b_array
      for (int i = HPE - 1; i >= 0; i--) begin
         for (int j = HPE - 1; j >= 0; j--) begin
            if (j == 0) pa = AA[i*WIDTH +: WIDTH];
            else        pa = ar_a[i][j-1];
            if (i == 0) pb = BB[j*WIDTH +: WIDTH];
            else        pb = ar_b[i-1][j];
            y_acc[i][j] = y_acc[i][j] + 64'(pa) * 64'(pb);
            ar_a[i][j]  = pa;
            ar_b[i][j]  = pb;
         end
      end
   end

   task automatic clear_arr();
      for (int i = 0; i < HPE; i++)
         for (int j = 0; j < HPE; j++) begin
            y_acc[i][j] = 0; ar_a[i][j] = '0; ar_b[i][j] = '0;
         end
   endtask

   logic [WIDTH-1:0] mat_a [HPE][HPE];
   logic [WIDTH-1:0] mat_b [HPE][HPE];

   function automatic logic [VW-1:0] slice_a(input int k);
      logic [VW-1:0] r;
      for (int i = 0; i < HPE; i++) r[i*WIDTH +: WIDTH] = mat_a[i][k];
      return r;
   endfunction

   function automatic logic [VW-1:0] slice_b(input int k);
      logic [VW-1:0] r;
      for (int j = 0; j < HPE; j++) r[j*WIDTH +: WIDTH] = mat_b[k][j];
      return r;
   endfunction

   function automatic logic [VW-1:0] rv();
      return VW'($urandom);
   endfunction

   task automatic drive(input logic s, input logic [KW-1:0] k, input logic v,
                        input logic [VW-1:0] a, input logic [VW-1:0] b);
      start = s; k_len = k; in_valid = v; a_vec = a; b_vec = b;
   endtask

   task automatic drive_idle();
      drive(1'b0, KW'($urandom), 1'b0, rv(), rv());
   endtask

   // One frame with random valid gaps and optional ignored start pokes.
   task automatic run_frame(input int k, input int pv, input bit poke, input bit mtx);
      bit got;
      bit v;
      bit s;
      int idx;
      got = 1'b0;
      drive(1'b1, KW'(k), 1'b0, rv(), rv());
      @(negedge CLK);
      for (int n = 0; n < 4 * k + 100; n++) begin
         if (m_done) begin
            got = 1'b1;
            break;
         end
         idx = k - m_left;
         v   = ($urandom_range(99) < pv);
         s   = poke && m_busy && ($urandom_range(3) == 0);
         if (mtx && m_ready) drive(s, KW'($urandom), v, slice_a(idx), slice_b(idx));
         else                drive(s, KW'($urandom), v, rv(), rv());
         @(negedge CLK);
      end
      chk("frame_done_seen", 64'(got), 64'd1);
      drive_idle();
   endtask

   task automatic check_y(input string nm);
      longint unsigned e;
      for (int i = 0; i < HPE; i++)
         for (int j = 0; j < HPE; j++) begin
            e = 0;
            for (int k = 0; k < HPE; k++) e = e + 64'(mat_a[i][k]) * 64'(mat_b[k][j]);
            chk(nm, y_acc[i][j], e);
         end
   endtask

   initial begin : b_watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : b_stim
      RST = 1'b1;
      drive(1'($urandom), KW'($urandom), 1'($urandom), rv(), rv());

      // Reset held with random inputs.
      for (int n = 0; n < 3; n++) begin
         @(negedge CLK);
         chk("rst_AA", 64'(AA), 64'd0);
         chk("rst_BB", 64'(BB), 64'd0);
         chk("rst_status", 64'({in_ready, busy, done}), 64'd0);
         drive(1'($urandom), KW'($urandom), 1'($urandom), rv(), rv());
      end
      RST = 1'b0;
      drive_idle();
      @(negedge CLK);
      chk("idle_after_rst", 64'({in_ready, busy, done}), 64'd0);

      // Single beat with hand-computed skew and done timing.
      drive(1'b1, KW'(1), 1'b0, rv(), rv());
      @(negedge CLK);
      chk("sb_ready", 64'(in_ready), 64'd1);
      drive(1'b0, KW'(0), 1'b1, 32'h04030201, 32'h08070605);
      for (int j = 1; j <= 10; j++) begin
         @(negedge CLK);
         for (int z = 0; z < HPE; z++) begin
            chk("sb_AA_lane", 64'(AA[z*WIDTH +: WIDTH]), (j == z + 1) ? 64'(z + 1) : 64'd0);
            chk("sb_BB_lane", 64'(BB[z*WIDTH +: WIDTH]), (j == z + 1) ? 64'(z + 5) : 64'd0);
         end
         chk("sb_done", 64'(done), (j == 9) ? 64'd1 : 64'd0);
         chk("sb_busy", 64'(busy), (j < 9) ? 64'd1 : 64'd0);
         drive_idle();
      end

      // start with k_len=0 is ignored.
      drive(1'b1, KW'(0), 1'b1, rv(), rv());
      for (int n = 0; n < 5; n++) begin
         @(negedge CLK);
         chk("k0_busy", 64'(busy), 64'd0);
         chk("k0_done", 64'(done), 64'd0);
         drive_idle();
      end

      // Stall bubble between beats 1 and 2, start poke during flush.
      drive(1'b1, KW'(3), 1'b0, rv(), rv());
      @(negedge CLK);
      drive(1'b0, KW'(0), 1'b1, rv(), rv());
      @(negedge CLK);
      drive(1'b0, KW'(0), 1'b1, rv(), rv());
      @(negedge CLK);
      drive(1'b0, KW'(0), 1'b0, rv(), rv());
      @(negedge CLK);
      chk("stall_ready", 64'(in_ready), 64'd1);
      drive(1'b0, KW'(0), 1'b1, rv(), rv());
      for (int j = 1; j <= 12; j++) begin
         @(negedge CLK);
         chk("stall_done", 64'(done), (j == 9) ? 64'd1 : 64'd0);
         chk("stall_ready_after", 64'(in_ready), 64'd0);
         if (j == 3) drive(1'b1, KW'(5), 1'b1, rv(), rv());
         else        drive_idle();
      end

      // Reset mid-LOAD after 2 of 4 beats.
      drive(1'b1, KW'(4), 1'b0, rv(), rv());
      @(negedge CLK);
      drive(1'b0, KW'(0), 1'b1, rv(), rv());
      @(negedge CLK);
      drive(1'b0, KW'(0), 1'b1, rv(), rv());
      @(negedge CLK);
      RST = 1'b1;
      drive(1'b0, KW'(0), 1'b1, rv(), rv());
      @(negedge CLK);
      RST = 1'b0;
      chk("mid_rst_AA", 64'(AA), 64'd0);
      chk("mid_rst_BB", 64'(BB), 64'd0);
      chk("mid_rst_status", 64'({in_ready, busy, done}), 64'd0);
      drive_idle();
      for (int n = 0; n < 20; n++) begin
         @(negedge CLK);
         chk("mid_rst_no_done", 64'(done), 64'd0);
         drive_idle();
      end
      run_frame(2, 100, 1'b0, 1'b0);

      // End-to-end: identity A, random B.
      for (int i = 0; i < HPE; i++)
         for (int j = 0; j < HPE; j++) begin
            mat_a[i][j] = (i == j) ? WIDTH'(1) : WIDTH'(0);
            mat_b[i][j] = WIDTH'($urandom);
         end
      @(negedge CLK);
      clear_arr();
      run_frame(HPE, 100, 1'b0, 1'b1);
      for (int i = 0; i < HPE; i++)
         for (int j = 0; j < HPE; j++)
            chk("e2e_identity_Y", y_acc[i][j], 64'(mat_b[i][j]));

      // End-to-end: random A and B with stalls and pokes.
      for (int i = 0; i < HPE; i++)
         for (int j = 0; j < HPE; j++) begin
            mat_a[i][j] = WIDTH'($urandom);
            mat_b[i][j] = WIDTH'($urandom);
         end
      @(negedge CLK);
      clear_arr();
      run_frame(HPE, 60, 1'b1, 1'b1);
      check_y("e2e_random_Y");

      // Random frames, then the longest legal frame.
      for (int f = 0; f < 10; f++)
         run_frame($urandom_range(1, 7), $urandom_range(30, 100), 1'b1, 1'b0);
      run_frame((1 << KW) - 1, 80, 1'b1, 1'b0);

      repeat (4) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
